// File: rtl/dual_port_ram_if.sv
// Bus bundle for dual_port_ram: both ports' command/data signals plus the collision flag.
// Latency: none (wires only); the RAM registers its read data and collision flag.
// Backpressure: none; every port accepts a command on every clock.
interface dual_port_ram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  we_a;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [DATA_WIDTH-1:0] din_a;
  logic [DATA_WIDTH-1:0] dout_a;
  logic                  we_b;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] din_b;
  logic [DATA_WIDTH-1:0] dout_b;
  logic                  collision;

  // Requester side: issues commands, receives read data and the collision flag.
  modport master (
    output we_a, addr_a, din_a, we_b, addr_b, din_b,
    input  dout_a, dout_b, collision
  );

  // RAM side.
  modport slave (
    input  we_a, addr_a, din_a, we_b, addr_b, din_b,
    output dout_a, dout_b, collision
  );
endinterface

// File: rtl/dual_port_ram.sv
// True dual-port read-first RAM, one clock; Port A wins same-address write collisions.
// Latency: 1 cycle for read data and for the collision flag. Optional macro DPRAM_COLLISION_STICKY_EN.
// Backpressure: none; both ports accept a read or write every cycle.
module dual_port_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input logic            clk,
  input logic            rst_n,
  dual_port_ram_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Storage is never reset; contents survive rst_n.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Both ports write the same word this cycle; Port B's write is dropped.
  logic hit;
  assign hit = bus.we_a & bus.we_b & (bus.addr_a == bus.addr_b);

  // Array writes; suppressed during reset, Port B gated off on a collision.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (bus.we_a) begin
        mem[bus.addr_a] <= bus.din_a;
      end
      if (bus.we_b && !hit) begin
        mem[bus.addr_b] <= bus.din_b;
      end
    end
  end

  // Registered reads; nonblocking update of mem makes these read-first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.dout_a <= '0;
      bus.dout_b <= '0;
    end else begin
      bus.dout_a <= mem[bus.addr_a];
      bus.dout_b <= mem[bus.addr_b];
    end
  end

  // Collision flag: sticky until reset, or a one-cycle pulse by default.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.collision <= 1'b0;
    end else begin
`ifdef DPRAM_COLLISION_STICKY_EN
      bus.collision <= bus.collision | hit;
`else
      bus.collision <= hit;
`endif
    end
  end

endmodule

// File: tb/tb_dual_port_ram.sv
// Self-checking bench for dual_port_ram using a reference memory and an expected-result queue.
// Latency: one clock per step; each step's expectation is popped just after its edge.
// Backpressure: not applicable.
module tb_dual_port_ram;

`ifdef DPRAM_COLLISION_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  dual_port_ram_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  dual_port_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] a;
    logic [7:0] b;
    logic       col;
    bit         chk_a;
    bit         chk_b;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model [16];
  bit         known [16];
  logic       col_m = 1'b0;
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Drive one cycle of stimulus, queue what the RAM must show after the edge, then check it.
  task automatic step(input logic rst, input logic wa, input logic [3:0] aa, input logic [7:0] da,
                      input logic wb, input logic [3:0] ab, input logic [7:0] db, input string tag);
    exp_t e;
    logic hit;
    @(negedge clk);
    rst_n       = ~rst;
    bus.we_a    = wa;
    bus.addr_a  = aa;
    bus.din_a   = da;
    bus.we_b    = wb;
    bus.addr_b  = ab;
    bus.din_b   = db;
    hit = wa && wb && (aa == ab);
    e.tag   = tag;
    e.chk_a = rst || known[aa];
    e.chk_b = rst || known[ab];
    e.a     = rst ? 8'h00 : model[aa];
    e.b     = rst ? 8'h00 : model[ab];
    if (rst) col_m = 1'b0;
    else     col_m = STICKY ? (col_m | hit) : hit;
    e.col   = col_m;
    if (!rst) begin
      // B first, then A, so A's data lands last on a shared address.
      if (wb) begin model[ab] = db; known[ab] = 1'b1; end
      if (wa) begin model[aa] = da; known[aa] = 1'b1; end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    if (e.chk_a) chk({e.tag, ".dout_a"}, bus.dout_a, e.a);
    if (e.chk_b) chk({e.tag, ".dout_b"}, bus.dout_b, e.b);
    chk({e.tag, ".collision"}, {7'b0, bus.collision}, {7'b0, e.col});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) known[i] = 1'b0;
    bus.we_a = 1'b0; bus.addr_a = '0; bus.din_a = '0;
    bus.we_b = 1'b0; bus.addr_b = '0; bus.din_b = '0;

    step(1, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, "reset");
    // A-only write then read back
    step(0, 1, 4'd1, 8'hAA, 0, 4'd0, 8'h00, "a_wr");
    step(0, 0, 4'd1, 8'h00, 0, 4'd0, 8'h00, "a_rd");
    // B-only write then read back
    step(0, 0, 4'd0, 8'h00, 1, 4'd2, 8'hBB, "b_wr");
    step(0, 0, 4'd1, 8'h00, 0, 4'd2, 8'h00, "b_rd");
    // both write, distinct addresses
    step(0, 1, 4'd3, 8'hCC, 1, 4'd4, 8'hDD, "both_wr");
    step(0, 0, 4'd3, 8'h00, 0, 4'd4, 8'h00, "both_rd");
    // same-address collision, A must win
    step(0, 1, 4'd5, 8'hEE, 1, 4'd5, 8'hFF, "coll_wr");
    step(0, 0, 4'd5, 8'h00, 0, 4'd5, 8'h00, "coll_rd");
    step(0, 0, 4'd5, 8'h00, 0, 4'd5, 8'h00, "coll_after");
    // shared read of one address
    step(0, 0, 4'd1, 8'h00, 0, 4'd1, 8'h00, "shared_rd");
    // cross-port read during write: old data first, new data one edge later
    step(0, 0, 4'd0, 8'h00, 1, 4'd6, 8'h11, "pre_wr6");
    step(0, 1, 4'd6, 8'h99, 0, 4'd6, 8'h00, "rdw_old");
    step(0, 0, 4'd6, 8'h00, 0, 4'd6, 8'h00, "rdw_new");
    // reset mid-sequence with write attempts that must be ignored
    step(1, 1, 4'd1, 8'h55, 1, 4'd2, 8'h66, "mid_reset");
    step(0, 0, 4'd1, 8'h00, 0, 4'd2, 8'h00, "post_reset");
    // collision right after reset, then a random mix over every address
    step(0, 1, 4'd15, 8'h3C, 1, 4'd15, 8'hC3, "coll_top");
    for (int i = 0; i < 16; i++)
      step(0, 1, 4'(i), 8'(i * 17 + 3), 1, 4'(15 - i), 8'(i * 5 + 1), "fill");
    for (int i = 0; i < 60; i++)
      step(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom), "rand");
    step(1, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, "final_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
